weight_server: RTL and testbench

WEIGHT_SERVER -- requirements
Module: weight_server

---
 rtl/snn_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 53 +++++
 rtl/weight_server.sv | 108 ++++++++++
 tb/tb_weight_server.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared constants for the spiking-network weight path: address/data widths
// and default weight-memory depth used by the weight server and neural units.
package snn_pkg;

  localparam int SNN_ADDR_W = 10;
  localparam int SNN_DATA_W = 32;
  localparam int SNN_DEPTH  = 1024;

  // Index width that never collapses to zero for single-entry arrays.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, priority pointer
// advances past the winner only when a grant is issued.
module rr_arbiter
  import snn_pkg::*;
#(
  parameter  int N  = 2,
  localparam int PW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] win_o
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    int            idx;
    logic [PW-1:0] ix;
    logic          found;
    gnt_o = '0;
    win_o = '0;
    found = 1'b0;
    idx   = 0;
    ix    = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      ix = PW'(idx);
      if (en_i && !found && req_i[ix]) begin
        found     = 1'b1;
        gnt_o[ix] = 1'b1;
        win_o     = ix;
      end
    end
  end

  always_comb begin
    ptr_d = (win_o == PW'(N - 1)) ? '0 : win_o + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (|gnt_o) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/weight_server.sv
// Shared weight memory serving several neural units: round-robin read port with
// fixed 2-cycle latency (RAM read, output register) and a priority load port.
module weight_server
  import snn_pkg::*;
#(
  parameter int NUM_UNITS = 2,
  parameter int ADDR_W    = SNN_ADDR_W,
  parameter int DATA_W    = SNN_DATA_W,
  parameter int DEPTH     = SNN_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_UNITS-1:0]        req,
  input  logic [NUM_UNITS*ADDR_W-1:0] addr,
  output logic [NUM_UNITS-1:0]        gnt,
  output logic [DATA_W-1:0]           wdata,
  output logic [NUM_UNITS-1:0]        wvalid,
  input  logic                        ld_en,
  input  logic [ADDR_W-1:0]           ld_addr,
  input  logic [DATA_W-1:0]           ld_data,
  output logic                        busy,
  output logic                        err
);

  localparam int PW = idx_w(NUM_UNITS);
  localparam int IW = idx_w(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  // Handshake: a unit raises req[i] with its address and holds both until
  // gnt[i]; the read is accepted in the cycle req[i] & gnt[i] is seen and
  // the data returns on wdata with a one-cycle wvalid[i] pulse two cycles later.
  logic              arb_en;
  logic [PW-1:0]     win;
  logic              acc;
  logic [ADDR_W-1:0] sel_addr;
  logic              rd_oor;
  logic              ld_ok;

  logic [DATA_W-1:0]    mem [DEPTH];
  logic [DATA_W-1:0]    rd_data_q;
  logic                 s1_valid_q;
  logic [NUM_UNITS-1:0] s1_unit_q;
  logic                 s1_oor_q;
  logic [NUM_UNITS-1:0] wvalid_q, wvalid_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 err_q, err_d;

  // Loads own the cycle, and nothing is granted while reset is held.
  assign arb_en = ~rst & ~ld_en;

  rr_arbiter #(.N(NUM_UNITS)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .en_i  (arb_en),
    .req_i (req),
    .gnt_o (gnt),
    .win_o (win)
  );

  assign acc = |gnt;

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (win == PW'(i)) sel_addr = addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign rd_oor = ({1'b0, sel_addr} >= DEPTH_L);
  assign ld_ok  = ({1'b0, ld_addr} < DEPTH_L);

  // Storage is deliberately outside the reset domain so weights survive rst.
  always_ff @(posedge clk) begin
    if (ld_en && !rst && ld_ok) mem[ld_addr[IW-1:0]] <= ld_data;
    if (acc) rd_data_q <= mem[sel_addr[IW-1:0]];
  end

  always_comb begin
    wvalid_d = s1_valid_q ? s1_unit_q : '0;
    wdata_d  = wdata_q;
    if (s1_valid_q) wdata_d = s1_oor_q ? '0 : rd_data_q;
    err_d    = err_q | (acc & rd_oor) | (ld_en & ~ld_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_unit_q  <= '0;
      s1_oor_q   <= 1'b0;
      wvalid_q   <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      s1_valid_q <= acc;
      s1_unit_q  <= gnt;
      s1_oor_q   <= acc & rd_oor;
      wvalid_q   <= wvalid_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
    end
  end

  assign wvalid = wvalid_q;
  assign wdata  = wdata_q;
  assign busy   = s1_valid_q | (|wvalid_q);
  assign err    = err_q;

endmodule

// File: tb/tb_weight_server.sv
// Bench for weight_server: directed scenarios then randomized traffic, checked
// against a round-robin / memory reference model with a timed expected queue.
module tb_weight_server;

  localparam int NU    = 2;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NU-1:0]     req;
  logic [NU*AW-1:0]  addr;
  logic [NU-1:0]     gnt;
  logic [DW-1:0]     wdata;
  logic [NU-1:0]     wvalid;
  logic              ld_en;
  logic [AW-1:0]     ld_addr;
  logic [DW-1:0]     ld_data;
  logic              busy;
  logic              err;

  weight_server #(
    .NUM_UNITS (NU),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .addr    (addr),
    .gnt     (gnt),
    .wdata   (wdata),
    .wvalid  (wvalid),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .busy    (busy),
    .err     (err)
  );

  // Entry layout: {due cycle[15:0], unit one-hot[1:0], data[31:0]}
  logic [49:0]   exp_q[$];
  logic [31:0]   mem_m [0:1023];
  int            ptr_m;
  logic          err_m;
  int            cyc;
  logic [NU-1:0] last_gnt;
  int            vectors;
  int            miscompares;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // One clock cycle: inputs are already driven; check outputs mid-cycle,
  // advance the reference model, then move to just after the next rising edge.
  task automatic step();
    logic [NU-1:0] g_e;
    logic [NU-1:0] wv_e;
    logic          busy_e;
    logic [AW-1:0] a;
    logic [31:0]   d;
    int            u;
    int            win;
    #3;
    if (rst) begin
      exp_q.delete();
      ptr_m = 0;
      err_m = 1'b0;
    end
    wv_e   = '0;
    busy_e = 1'b0;
    if (exp_q.size() > 0 && exp_q[0][49:34] == 16'(cyc)) begin
      wv_e = exp_q[0][33:32];
      chk("wdata", 64'(wdata), 64'(exp_q[0][31:0]));
      void'(exp_q.pop_front());
    end
    foreach (exp_q[k]) if (exp_q[k][49:34] == 16'(cyc + 1)) busy_e = 1'b1;
    if (wv_e != '0) busy_e = 1'b1;
    if (rst) chk("wdata_rst", 64'(wdata), 64'(0));
    chk("wvalid", 64'(wvalid), 64'(wv_e));
    chk("busy", 64'(busy), 64'(busy_e));
    chk("err", 64'(err), 64'(err_m));

    g_e = '0;
    win = 0;
    if (!rst && !ld_en && req != '0) begin
      for (int k = 0; k < NU; k++) begin
        u = (ptr_m + k) % NU;
        if (g_e == '0 && req[u]) begin
          g_e[u] = 1'b1;
          win    = u;
        end
      end
    end
    chk("gnt", 64'(gnt), 64'(g_e));

    if (g_e != '0) begin
      a = addr[win*AW +: AW];
      if (a >= DEPTH) begin
        d     = '0;
        err_m = 1'b1;
      end else begin
        d = mem_m[a];
      end
      exp_q.push_back({16'(cyc + 2), g_e, d});
      ptr_m = (win + 1) % NU;
    end
    if (!rst && ld_en) begin
      if (ld_addr < DEPTH) mem_m[ld_addr] = ld_data;
      else err_m = 1'b1;
    end
    last_gnt = g_e;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    ptr_m       = 0;
    err_m       = 1'b0;
    last_gnt    = '0;
    rst         = 1'b1;
    req         = 2'b11;
    addr        = '0;
    ld_en       = 1'b0;
    ld_addr     = '0;
    ld_data     = '0;
    #1;

    // Reset state, with requests pending: no grants, outputs clear.
    step();
    step();
    rst = 1'b0;
    req = '0;
    step();

    // Single load then single read of address 5.
    ld_en = 1'b1; ld_addr = 10'd5; ld_data = 32'h0000_000C;
    step();
    ld_en = 1'b0;
    req = 2'b01; addr[0 +: AW] = 10'd5;
    step();
    req = '0;
    repeat (3) step();

    // Both units streaming from addresses 1 and 2.
    ld_en = 1'b1; ld_addr = 10'd1; ld_data = 32'h0000_000A;
    step();
    ld_addr = 10'd2; ld_data = 32'h0000_000B;
    step();
    ld_en = 1'b0;
    req = 2'b11; addr = {10'd2, 10'd1};
    repeat (8) step();
    req = '0;
    repeat (3) step();

    // Load blocks grants; the following read sees the new value.
    ld_en = 1'b1; ld_addr = 10'd3; ld_data = 32'h0000_0033;
    req = 2'b11; addr = {10'd3, 10'd3};
    step();
    ld_en = 1'b0;
    repeat (2) step();
    req = '0;
    repeat (3) step();

    // Unit 0 alone, back-to-back for 4 cycles.
    req = 2'b01; addr[0 +: AW] = 10'd1;
    repeat (4) step();
    req = '0;
    repeat (4) step();

    // Out-of-range read by unit 1: zero data, sticky err.
    req = 2'b10; addr[AW +: AW] = 10'd600;
    step();
    req = '0;
    repeat (4) step();

    // Reset one cycle after an accept; a load during reset must be ignored.
    req = 2'b01; addr[0 +: AW] = 10'd5;
    step();
    rst = 1'b1; req = 2'b11;
    ld_en = 1'b1; ld_addr = 10'd5; ld_data = 32'hDEAD_BEEF;
    step();
    step();
    rst = 1'b0; ld_en = 1'b0; req = '0;
    repeat (3) step();
    req = 2'b01; addr[0 +: AW] = 10'd5;
    step();
    req = '0;
    repeat (3) step();

    // Out-of-range load aliasing address 5 must not write and must set err.
    ld_en = 1'b1; ld_addr = 10'd517; ld_data = 32'h0000_0BAD;
    step();
    ld_en = 1'b0;
    step();
    req = 2'b01; addr[0 +: AW] = 10'd5;
    step();
    req = '0;
    repeat (3) step();

    // Randomized traffic over a preloaded window.
    for (int i = 0; i < 16; i++) begin
      ld_en = 1'b1; ld_addr = 10'(i); ld_data = $urandom;
      step();
    end
    ld_en = 1'b0;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NU; i++) begin
        if (!(req[i] && !last_gnt[i])) begin
          req[i] = ($urandom_range(0, 2) != 0);
          addr[i*AW +: AW] = ($urandom_range(0, 19) == 0) ? 10'd600 : 10'($urandom_range(0, 15));
        end
      end
      ld_en   = ($urandom_range(0, 7) == 0);
      ld_addr = ($urandom_range(0, 9) == 0) ? 10'(512 + $urandom_range(0, 15)) : 10'($urandom_range(0, 15));
      ld_data = $urandom;
      step();
    end
    req   = '0;
    ld_en = 1'b0;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
